// File: rtl/rv_pkg.sv
// rv_pkg: opcode and funct3 constants shared by the execute and write-back
// stages, plus small decode helpers that classify an opcode.
//
// Contents:
//   XLEN            datapath width (only 32 is supported)
//   OPC_*           7-bit major opcodes used by the core
//   F3_L* / F3_S*   load/store width encodings carried in func3
//   is_mem_op()     opcode performs a memory transaction
//   writes_rd()     opcode produces a register-file result
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Loads and stores are the only instructions that talk to memory.
  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // Branches and stores never write rd; unknown opcodes are treated the same.
  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_LUI)    || (opc == OPC_AUIPC) ||
           (opc == OPC_OP_IMM) || (opc == OPC_OP)    ||
           (opc == OPC_LOAD)   || (opc == OPC_JAL)   ||
           (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword/word out of a 32-bit memory
// read word and sign- or zero-extends it according to the load func3.
//
// Ports:
//   rdata  in  XLEN  raw word returned by memory (word-aligned address)
//   off    in  2     byte offset of the access within the word
//   func3  in  3     load width/signedness (LB/LH/LW/LBU/LHU)
//   data   out XLEN  extended load value
module load_align
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword selection deliberately looks at off[1] only, so a misaligned
  // halfword at offset 1 or 3 silently reads the enclosing aligned half.
  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'h000000, byte_sel};
      F3_LHU:  data = {16'h0000, half_sel};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wbu.sv
// wbu: write-back/commit stage. Accepts one executed instruction per
// in_valid/in_ready handshake, runs the load/store memory transaction if
// needed, then commits: one rf write pulse plus the next-PC handoff to fetch.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid / in_ready         instruction handshake from execute
//   opcode, func3, rd, pc, imm  instruction fields
//   exu_res                     ALU result (address / branch cond / target / value)
//   rs2_data                    store data
//   mem_req_valid / ready       memory request handshake
//   mem_wen, mem_addr,
//   mem_wdata, mem_wmask        registered request payload
//   mem_rsp_valid, mem_rdata    memory response
//   rf_wen, rf_waddr, rf_wdata  register-file write port
//   pc_valid / pc_ready,
//   next_pc                     next-PC handshake to fetch
module wbu
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] exu_res,
  input  logic [XLEN-1:0] rs2_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pc_valid,
  input  logic            pc_ready,
  output logic [XLEN-1:0] next_pc
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  state_t state, state_next;

  logic            accept;
  logic [1:0]      off;
  logic            mem_op;
  logic            store_op;
  logic [3:0]      st_mask;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] wb_value;
  logic [XLEN-1:0] npc_value;
  logic [XLEN-1:0] pc_plus4;

  // Only the pieces needed after accept are kept: the load flavour and byte
  // offset for alignment, and whether the commit writes rd at all.
  logic            load_q;
  logic [2:0]      func3_q;
  logic [1:0]      off_q;
  logic            wr_q;
  logic [XLEN-1:0] load_data;

  assign accept   = (state == IDLE) && in_valid;
  assign off      = exu_res[1:0];
  assign mem_op   = is_mem_op(opcode);
  assign store_op = (opcode == OPC_STORE);
  assign pc_plus4 = pc + 32'd4;

  // Store lane enables and replicated write data, formed from the raw
  // execute outputs so they can be registered on the accept edge.
  always_comb begin
    case (func3)
      F3_SB: begin
        st_mask = 4'b0001 << off;
        st_data = {4{rs2_data[7:0]}};
      end
      F3_SH: begin
        st_mask = 4'b0011 << {off[1], 1'b0};
        st_data = {2{rs2_data[15:0]}};
      end
      default: begin
        st_mask = 4'hF;
        st_data = rs2_data;
      end
    endcase
  end

  // Result and next PC are known at accept time except for load data,
  // which overwrites rf_wdata when the response arrives.
  always_comb begin
    case (opcode)
      OPC_JAL, OPC_JALR: wb_value = pc_plus4;
      OPC_LOAD:          wb_value = '0;
      default:           wb_value = exu_res;
    endcase
    case (opcode)
      OPC_BRANCH: npc_value = exu_res[0] ? (pc + imm) : pc_plus4;
      OPC_JAL:    npc_value = exu_res;
      OPC_JALR:   npc_value = exu_res & ~32'h1;
      default:    npc_value = pc_plus4;
    endcase
  end

  load_align u_load_align (
    .rdata (mem_rdata),
    .off   (off_q),
    .func3 (func3_q),
    .data  (load_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. rf_wen is qualified by pc_ready so the
  // register write lands on exactly the cycle fetch takes the next PC.
  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    pc_valid      = 1'b0;
    rf_wen        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = mem_op ? MEM_REQ : COMMIT;
        end
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        pc_valid = 1'b1;
        if (pc_ready) begin
          rf_wen     = wr_q;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered payloads. Everything is captured on accept and then held
  // untouched, so the request and commit payloads stay stable under stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'h0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= '0;
      next_pc   <= '0;
      load_q    <= 1'b0;
      func3_q   <= 3'd0;
      off_q     <= 2'd0;
      wr_q      <= 1'b0;
    end else if (accept) begin
      mem_wen   <= store_op;
      mem_addr  <= mem_op ? {exu_res[31:2], 2'b00} : '0;
      mem_wdata <= store_op ? st_data : '0;
      mem_wmask <= store_op ? st_mask : 4'h0;
      rf_waddr  <= rd;
      rf_wdata  <= wb_value;
      next_pc   <= npc_value;
      load_q    <= (opcode == OPC_LOAD);
      func3_q   <= func3;
      off_q     <= off;
      wr_q      <= writes_rd(opcode) && (rd != 5'd0);
    end else if ((state == MEM_WAIT) && mem_rsp_valid && load_q) begin
      rf_wdata  <= load_data;
    end
  end

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: randomized scoreboard bench for the write-back stage. The driver
// issues instructions and pushes expected memory requests and commits into
// queues; an independent negedge monitor compares whatever the DUT presents.
module tb_wbu;
  import rv_pkg::*;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] exu_res;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          s;
    int          d;
    int          p;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } exp_mem_t;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] next_pc;
    int          cyc;
  } exp_commit_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] exu_res;
  logic [31:0] rs2_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] next_pc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_mem_t    exp_mem[$];
  exp_commit_t exp_commit[$];

  wbu dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .func3         (func3),
    .rd            (rd),
    .pc            (pc),
    .imm           (imm),
    .exu_res       (exu_res),
    .rs2_data      (rs2_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .next_pc       (next_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the stage must do for one instruction, worked out
  // from the ISA rules with plain arithmetic on bytes and halfwords.
  function automatic void model(input txn_t t, output exp_mem_t m, output exp_commit_t c);
    int          off;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] ld;
    logic        writes;
    off     = int'(t.exu_res[1:0]);
    m.addr  = t.exu_res - 32'(off);
    m.wen   = (t.opcode == OPC_STORE);
    m.wmask = 4'hF;
    m.wdata = t.rs2;
    if (t.func3 == F3_SB) begin
      m.wmask = 4'(1 << off);
      m.wdata = (t.rs2 & 32'hFF) * 32'h01010101;
    end else if (t.func3 == F3_SH) begin
      m.wmask = 4'(3 << (2 * (off / 2)));
      m.wdata = (t.rs2 & 32'hFFFF) * 32'h00010001;
    end
    b = (t.rdata >> (8 * off)) & 32'hFF;
    h = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (t.func3)
      F3_LB:   ld = (b >= 32'd128) ? b - 32'd256 : b;
      F3_LH:   ld = (h >= 32'd32768) ? h - 32'd65536 : h;
      F3_LBU:  ld = b;
      F3_LHU:  ld = h;
      default: ld = t.rdata;
    endcase
    writes = !(t.opcode == OPC_BRANCH || t.opcode == OPC_STORE);
    c.wen   = writes && (t.rd != 0);
    c.waddr = t.rd;
    if (t.opcode == OPC_LOAD) c.wdata = ld;
    else if (t.opcode == OPC_JAL || t.opcode == OPC_JALR) c.wdata = t.pc + 4;
    else c.wdata = t.exu_res;
    if (t.opcode == OPC_BRANCH && t.exu_res[0]) c.next_pc = t.pc + t.imm;
    else if (t.opcode == OPC_JAL) c.next_pc = t.exu_res;
    else if (t.opcode == OPC_JALR) c.next_pc = {t.exu_res[31:1], 1'b0};
    else c.next_pc = t.pc + 4;
    c.cyc = 0;
  endfunction

  function automatic txn_t mkTxn(input logic [6:0] o, input logic [2:0] f, input logic [4:0] r,
                                 input logic [31:0] p_c, input logic [31:0] im, input logic [31:0] ex,
                                 input logic [31:0] r2, input logic [31:0] rdat,
                                 input int s, input int d, input int p);
    txn_t t;
    t.opcode = o; t.func3 = f; t.rd = r; t.pc = p_c; t.imm = im; t.exu_res = ex;
    t.rs2 = r2; t.rdata = rdat; t.s = s; t.d = d; t.p = p;
    return t;
  endfunction

  // Presents one instruction, pushes its expectations and plays memory and
  // fetch, including ready stalls and stray responses outside MEM_WAIT.
  task automatic applyStimulus(input txn_t t, input bit push_commit);
    exp_mem_t    m;
    exp_commit_t c;
    bit          is_mem;
    int          n;
    int          acc;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    is_mem = (t.opcode == OPC_LOAD) || (t.opcode == OPC_STORE);
    model(t, m, c);
    acc   = cyc + 1;
    c.cyc = acc + 1 + (is_mem ? (t.s + t.d + 1) : 0) + t.p;
    if (is_mem) exp_mem.push_back(m);
    if (push_commit) exp_commit.push_back(c);
    in_valid = 1'b1; opcode = t.opcode; func3 = t.func3; rd = t.rd;
    pc = t.pc; imm = t.imm; exu_res = t.exu_res; rs2_data = t.rs2;
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = 7'($urandom); exu_res = $urandom; rs2_data = $urandom;
    pc = $urandom; imm = $urandom; rd = 5'($urandom); func3 = 3'($urandom);
    if (is_mem) begin
      for (int i = 0; i < t.s; i++) begin
        mem_rsp_valid = 1'($urandom);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'($urandom);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (!push_commit) return;
      repeat (t.d - 1) begin
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b1;
      mem_rdata     = t.rdata;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rdata     = $urandom;
    end
    pc_ready = (t.p == 0);
    repeat (t.p) begin
      @(posedge clk); #1;
    end
    pc_ready = 1'b1;
    @(posedge clk); #1;
    pc_ready = 1'b0;
  endtask

  // Monitor: compares the request and commit payloads against the front of
  // each queue every cycle they are valid, popping on the handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid) begin
        checkOutput("in_ready_in_mem", {31'd0, in_ready}, 32'd0);
        if (exp_mem.size() == 0) begin
          checkOutput("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          checkOutput("mem_addr", mem_addr, exp_mem[0].addr);
          checkOutput("mem_wen", {31'd0, mem_wen}, {31'd0, exp_mem[0].wen});
          if (exp_mem[0].wen) begin
            checkOutput("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_mem[0].wmask});
            checkOutput("mem_wdata", mem_wdata, exp_mem[0].wdata);
          end
          if (mem_req_ready) void'(exp_mem.pop_front());
        end
      end
      if (pc_valid) begin
        checkOutput("in_ready_in_commit", {31'd0, in_ready}, 32'd0);
        if (exp_commit.size() == 0) begin
          checkOutput("unexpected_pc_valid", 32'd1, 32'd0);
        end else begin
          checkOutput("next_pc", next_pc, exp_commit[0].next_pc);
          if (pc_ready) begin
            checkOutput("rf_wen", {31'd0, rf_wen}, {31'd0, exp_commit[0].wen});
            checkOutput("commit_cycle", 32'(cyc + 1), 32'(exp_commit[0].cyc));
            if (exp_commit[0].wen) begin
              checkOutput("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_commit[0].waddr});
              checkOutput("rf_wdata", rf_wdata, exp_commit[0].wdata);
            end
            void'(exp_commit.pop_front());
          end else begin
            checkOutput("rf_wen_stall", {31'd0, rf_wen}, 32'd0);
          end
        end
      end else if (rf_wen) begin
        checkOutput("rf_wen_no_commit", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    txn_t t;
    logic [6:0] opcs [9];
    rst = 1'b1; in_valid = 1'b0; opcode = '0; func3 = '0; rd = '0; pc = '0; imm = '0;
    exu_res = '0; rs2_data = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rdata = '0; pc_ready = 1'b0;
    opcs = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
             OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP};
    #3;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("reset_pc_valid", {31'd0, pc_valid}, 32'd0);
    checkOutput("reset_rf_wen", {31'd0, rf_wen}, 32'd0);
    checkOutput("reset_next_pc", next_pc, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(mkTxn(OPC_OP, 3'd0, 5'd5, 32'h80000000, 32'd0, 32'h1234, 32'd0, 32'd0, 0, 1, 0), 1'b1);
    applyStimulus(mkTxn(OPC_LOAD, F3_LB, 5'd7, 32'h200, 32'd0, 32'h80000103, 32'd0, 32'h80FF0000, 0, 3, 0), 1'b1);
    applyStimulus(mkTxn(OPC_LOAD, F3_LBU, 5'd8, 32'h204, 32'd0, 32'h80000103, 32'd0, 32'h80FF0000, 0, 3, 1), 1'b1);
    applyStimulus(mkTxn(OPC_STORE, F3_SH, 5'd3, 32'h300, 32'd0, 32'h1002, 32'hABCD1234, 32'd0, 2, 2, 0), 1'b1);
    applyStimulus(mkTxn(OPC_BRANCH, 3'd0, 5'd4, 32'h100, 32'hFFFFFFF0, 32'h1, 32'd0, 32'd0, 0, 1, 0), 1'b1);
    applyStimulus(mkTxn(OPC_BRANCH, 3'd1, 5'd4, 32'h100, 32'hFFFFFFF0, 32'h0, 32'd0, 32'd0, 0, 1, 2), 1'b1);
    applyStimulus(mkTxn(OPC_JALR, 3'd0, 5'd0, 32'h400, 32'd0, 32'h2001, 32'd0, 32'd0, 0, 1, 0), 1'b1);
    applyStimulus(mkTxn(OPC_JAL, 3'd0, 5'd1, 32'h500, 32'h40, 32'h540, 32'd0, 32'd0, 0, 1, 0), 1'b1);

    $display("[TB] reset during MEM_WAIT");
    applyStimulus(mkTxn(OPC_LOAD, F3_LW, 5'd9, 32'h600, 32'd0, 32'h3000, 32'd0, 32'hDEADBEEF, 0, 1, 0), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
    checkOutput("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    checkOutput("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_next_pc", next_pc, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    pc_ready = 1'b1;
    repeat (3) begin
      checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("post_rst_pc_valid", {31'd0, pc_valid}, 32'd0);
      @(posedge clk); #1;
    end
    pc_ready = 1'b0;

    $display("[TB] random cases");
    for (int k = 0; k < 200; k++) begin
      t.opcode  = opcs[$urandom_range(0, 8)];
      t.func3   = 3'($urandom);
      if (t.opcode == OPC_LOAD) begin
        case ($urandom_range(0, 4))
          0: t.func3 = F3_LB;
          1: t.func3 = F3_LH;
          2: t.func3 = F3_LW;
          3: t.func3 = F3_LBU;
          default: t.func3 = F3_LHU;
        endcase
      end else if (t.opcode == OPC_STORE) begin
        case ($urandom_range(0, 2))
          0: t.func3 = F3_SB;
          1: t.func3 = F3_SH;
          default: t.func3 = F3_SW;
        endcase
      end
      t.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      t.pc      = $urandom;
      t.imm     = $urandom;
      t.exu_res = $urandom;
      t.rs2     = $urandom;
      t.rdata   = $urandom;
      t.s       = $urandom_range(0, 2);
      t.d       = $urandom_range(1, 4);
      t.p       = $urandom_range(0, 2);
      applyStimulus(t, 1'b1);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    checkOutput("commit_queue_drained", 32'(exp_commit.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbu.md
# wbu

Write-back/commit stage of the multicycle core, sitting downstream of the execute unit. It accepts one executed instruction per valid/ready handshake: opcode, func3, rd, pc, imm, ALU result and store data. It performs the load/store memory transaction with variable-latency memory, then commits the instruction in one cycle by writing the register file and handing the next PC back to fetch.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- opcode  in  7, func3  in  3, rd  in  5  instruction fields.
- pc  in  XLEN, imm  in  XLEN  instruction PC and decoded immediate.
- exu_res  in  XLEN  ALU result: address for load/store, branch condition in bit 0 for branches, target for JAL/JALR, value otherwise.
- rs2_data  in  XLEN  store data.
- mem_req_valid  out  1, mem_req_ready  in  1  memory request handshake.
- mem_wen  out  1, mem_addr  out  XLEN, mem_wdata  out  XLEN, mem_wmask  out  4  request payload; mem_addr is word-aligned.
- mem_rsp_valid  in  1, mem_rdata  in  XLEN  response; arrives one or more cycles after request acceptance, for loads and stores alike.
- rf_wen  out  1, rf_waddr  out  5, rf_wdata  out  XLEN  register-file write port.
- pc_valid  out  1, pc_ready  in  1, next_pc  out  XLEN  next-PC handshake to fetch.

## Operation
- FSM states: IDLE, MEM_REQ, MEM_WAIT, COMMIT.
- IDLE: in_ready=1.
  - On in_valid, latch all inputs.
  - Go to MEM_REQ for LOAD/STORE opcodes, otherwise to COMMIT.
- MEM_REQ: mem_req_valid=1 with stable payload until mem_req_ready, then go to MEM_WAIT.
- MEM_WAIT: wait for mem_rsp_valid.
  - For loads, latch the aligned/extended data.
  - Go to COMMIT.
- COMMIT: pc_valid=1 until pc_ready.
  - On the handshake cycle, rf_wen pulses for exactly one cycle, then the FSM returns to IDLE.
- Byte offset is off = exu_res[1:0]. mem_addr = {exu_res[31:2], 2'b00}.
- Stores:
  - SB: wmask = 4'b0001<<off; wdata = byte replicated ×4.
  - SH: wmask = 4'b0011<<{off[1],1'b0}; wdata = half replicated ×2.
  - SW: wmask = 4'hF.
  - mem_wen = 1.
- Loads select from mem_rdata by offset:
  - LB/LH/LW: sign-extend.
  - LBU/LHU: zero-extend.
  - Halfword select uses off[1] only.
  - Misaligned accesses raise no trap.
- Register write data:
  - LUI/AUIPC/OP-IMM/OP: exu_res.
  - LOAD: extended data.
  - JAL/JALR: pc+4.
  - BRANCH/STORE: no write.
- rf_wen is suppressed when rd==0.
- next_pc:
  - Branch taken (exu_res[0]=1): pc+imm.
  - JAL: exu_res.
  - JALR: exu_res & ~32'h1.
  - Otherwise: pc+4.
- All adds are modulo 2^32.

## Timing
- Reset values: state=IDLE, in_ready=1; all other outputs 0, including latched payload and next_pc.
- Latency from accept edge:
  - Non-memory: COMMIT entered the next cycle. With pc_ready=1, commit occurs 1 cycle after accept.
  - Memory: request 1 cycle after accept, plus request-stall cycles, plus response delay, plus 1 COMMIT cycle.
- in_ready deasserts the cycle after accept. No new instruction is accepted in the same cycle as a commit; IDLE costs one cycle.
- mem_rsp_valid outside MEM_WAIT is ignored.
- rst mid-operation drops the in-flight instruction with no rf write and no pc_valid.
- Payload outputs are registered and held stable while the corresponding valid is high.

## Structure
- Shared package rv_pkg holds opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP-IMM, OP) and load/store func3 encodings, reused with the execute unit.
- The FSM state enum is local.
- One combinational sub-module, load_align: inputs rdata, off, func3; output the extended 32-bit load value.

## Test plan
- ADD result: opcode OP, rd=5, exu_res=0x1234, pc=0x80000000, pc_ready=1 -> one rf_wen pulse writing x5=0x1234, next_pc=0x80000004, commit 1 cycle after accept.
- LB with sign extension: exu_res=0x80000103, mem_rdata=0x80FF0000, 3-cycle response delay -> mem_addr=0x80000100, rf_wdata=0xFFFFFF80. LBU on the same input -> 0x00000080.
- SH: exu_res=0x1002, rs2_data=0xABCD1234, mem_req_ready low for 2 cycles -> payload held stable, wmask=4'b1100, wdata=0x12341234, no rf_wen, next_pc=pc+4.
- Branch: exu_res[0]=1, pc=0x100, imm=0xFFFFFFF0 -> next_pc=0xF0. Same with exu_res[0]=0 -> next_pc=0x104, no rf write.
- JALR rd=0, exu_res=0x2001 -> next_pc=0x2000, rf_wen stays 0. JAL rd=1 -> x1=pc+4.
- rst asserted in MEM_WAIT, then mem_rsp_valid -> outputs 0 immediately, no rf_wen/pc_valid, in_ready=1 after reset release.
